if_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register of the 4-stage ARM-subset pipeline.
- Holds the PC and drives the instruction-memory address. Captures the returned 32-bit word.
- Presents decoded instruction fields to the control unit: condition[31:28], format[27:26], controls[25:21], set_condition[20].
- Handles stall, flush and branch redirect from downstream stages, and keeps a retired-fetch counter for debug.

---
 rtl/if_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage with IF/ID pipeline register, branch
//            redirect, stall/flush handling and a retired-fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int unsigned              ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    branch_taken,
    input  logic [ADDR_WIDTH-1:0]   branch_target,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [31:0]             imem_data,
    output logic                    valid,
    output logic [ADDR_WIDTH-1:0]   pc_out,
    output logic [31:0]             instr,
    output logic [3:0]              condition,
    output logic [1:0]              format,
    output logic [4:0]              controls,
    output logic                    set_condition,
    output logic [CNT_WIDTH-1:0]    fetch_count
);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_valid;
    logic [ADDR_WIDTH-1:0]  r_pc_out;
    logic [31:0]            r_instr;
    logic [CNT_WIDTH-1:0]   r_fetch_count;

    logic                   w_bubble;
    logic                   w_load;
    logic [31:0]            w_instr;

    // A taken branch squashes the wrong-path word even when a stall is pending.
    assign w_bubble = branch_taken | flush;
    assign w_load   = ~w_bubble & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= branch_target;
        end else if (!stall) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc_out      <= '0;
            r_instr       <= '0;
            r_fetch_count <= '0;
        end else if (w_bubble) begin
            r_valid  <= 1'b0;
            r_pc_out <= '0;
            r_instr  <= '0;
        end else if (w_load) begin
            r_valid       <= 1'b1;
            r_pc_out      <= r_pc;
            r_instr       <= imem_data;
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    // Bubbles always present all-zero fields regardless of register contents.
    assign w_instr       = r_valid ? r_instr : 32'h0;

    assign imem_addr     = r_pc;
    assign valid         = r_valid;
    assign pc_out        = r_pc_out;
    assign instr         = w_instr;
    assign condition     = w_instr[31:28];
    assign format        = w_instr[27:26];
    assign controls      = w_instr[25:21];
    assign set_condition = w_instr[20];
    assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire
